// File: rtl/dram_nxb_pipe.sv
// dram_nxb_pipe: byte-banked data RAM with valid/ready request and response
// channels. Reads return through a short pipeline (RD_LAT 1 or 2) followed by
// a show-ahead response FIFO with empty bypass. A credit counter limits
// outstanding reads to CAP = RD_LAT+1, so the FIFO can never overflow.
module dram_nxb_pipe #(
  parameter int NBYTES = 4,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  localparam int DATA_W = 8 * NBYTES,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [NBYTES-1:0] i_req_be,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int CAP   = RD_LAT + 1;
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int PTR_W = $clog2(CAP);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $fatal(1, "dram_nxb_pipe: RD_LAT must be 1 or 2");
  end

  // Expand the byte enables into a bit mask over the data word.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [NBYTES-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int k = 0; k < NBYTES; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

  // Circular FIFO pointer advance; CAP need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CAP - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept, rd_acc, wr_acc, addr_ok;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_data_q [CAP];
  logic              fifo_err_q  [CAP];
  logic              fifo_empty, push, pop, fifo_pop;

  logic              vld_p0_q;
  logic [DATA_W-1:0] rdata_p0_q;
  logic              err_p0_q;
  logic              arr_vld, arr_err;
  logic [DATA_W-1:0] arr_data;
  logic [DATA_W-1:0] head_data;
  logic              head_err;

  // Reset gates ready so nothing is accepted while aresetn is low.
  assign o_req_ready = aresetn && (cnt_q < CNT_W'(CAP));
  assign accept      = i_req_valid & o_req_ready;
  assign rd_acc      = accept & ~i_req_wen;
  assign wr_acc      = accept & i_req_wen;
  assign addr_ok     = ({1'b0, i_req_addr} < DEPTH_L);

  // Byte-masked array write; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && addr_ok) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_req_be[k]) mem_q[i_req_addr][8*k +: 8] <= i_req_wdata[8*k +: 8];
      end
    end
  end

  // Stage p0: sample the array at the accept edge, lane-masked.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rdata_p0_q <= addr_ok ? (mem_q[i_req_addr] & lane_mask(i_req_be)) : '0;
      err_p0_q   <= ~addr_ok;
    end
  end

  // Stage p0 valid.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) vld_p0_q <= 1'b0;
    else          vld_p0_q <= rd_acc;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              vld_p1_q;
    logic [DATA_W-1:0] rdata_p1_q;
    logic              err_p1_q;

    // Stage p1: output register after the array.
    always_ff @(posedge clk) begin
      if (vld_p0_q) begin
        rdata_p1_q <= rdata_p0_q;
        err_p1_q   <= err_p0_q;
      end
    end

    // Stage p1 valid.
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) vld_p1_q <= 1'b0;
      else          vld_p1_q <= vld_p0_q;
    end

    assign arr_vld  = vld_p1_q;
    assign arr_data = rdata_p1_q;
    assign arr_err  = err_p1_q;
  end else begin : g_lat1
    assign arr_vld  = vld_p0_q;
    assign arr_data = rdata_p0_q;
    assign arr_err  = err_p0_q;
  end

  // Show-ahead FIFO with bypass: an arrival goes straight out when the FIFO
  // is empty, and is stored only if it cannot be consumed this cycle.
  assign fifo_empty = (fcnt_q == '0);
  assign o_rsp_valid = fifo_empty ? arr_vld : 1'b1;
  assign head_data   = fifo_empty ? arr_data : fifo_data_q[rd_ptr_q];
  assign head_err    = fifo_empty ? arr_err  : fifo_err_q[rd_ptr_q];
  assign o_rsp_rdata = o_rsp_valid ? head_data : '0;
  assign o_rsp_err   = o_rsp_valid & head_err;
  assign pop         = o_rsp_valid & i_rsp_ready;
  assign push        = arr_vld & ~(fifo_empty & i_rsp_ready);
  assign fifo_pop    = pop & ~fifo_empty;

  // Next-state for the credit and FIFO occupancy counters.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(rd_acc) - CNT_W'(pop);
    fcnt_d = fcnt_q + CNT_W'(push) - CNT_W'(fifo_pop);
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= arr_data;
      fifo_err_q[wr_ptr_q]  <= arr_err;
    end
  end

  // Credit counter and FIFO pointers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      if (push)     wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

endmodule

// File: tb/tb_dram_nxb_pipe.sv
// Directed bench for dram_nxb_pipe: u0 (DEPTH=1000, RD_LAT=1) and
// u1 (DEPTH=1000, RD_LAT=2) share the request inputs; each check targets one.
module tb_dram_nxb_pipe;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        req_valid, req_wen, rsp_ready;
  logic [3:0]  req_be;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        r0, v0, e0, r1, v1, e1;
  logic [31:0] d0, d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_nxb_pipe #(.NBYTES(4), .DEPTH(1000), .RD_LAT(1)) u0 (
    .clk(clk), .aresetn(aresetn), .i_req_valid(req_valid), .o_req_ready(r0),
    .i_req_wen(req_wen), .i_req_be(req_be), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(v0), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(d0), .o_rsp_err(e0));

  dram_nxb_pipe #(.NBYTES(4), .DEPTH(1000), .RD_LAT(2)) u1 (
    .clk(clk), .aresetn(aresetn), .i_req_valid(req_valid), .o_req_ready(r1),
    .i_req_wen(req_wen), .i_req_be(req_be), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(v1), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(d1), .o_rsp_err(e1));

  typedef struct {
    logic        wen;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic w, input logic [3:0] be,
                     input logic [9:0] a, input logic [31:0] wd);
    req_valid = v; req_wen = w; req_be = be; req_addr = a; req_wdata = wd;
  endtask

  task automatic idle(input int n);
    req(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    repeat (n) cyc();
  endtask

  initial begin
    int acc;
    logic [31:0] exp_q [3];

    vt[0]  = '{1'b1, 4'hF, 10'd5,    32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 4'hF, 10'd5,    32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 4'h2, 10'd5,    32'h0000AA00, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 4'hF, 10'd5,    32'h0,        32'hDEADAAEF, 1'b0};
    vt[4]  = '{1'b0, 4'h5, 10'd5,    32'h0,        32'h00AD00EF, 1'b0};
    vt[5]  = '{1'b1, 4'h0, 10'd5,    32'h12345678, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 4'hF, 10'd5,    32'h0,        32'hDEADAAEF, 1'b0};
    vt[7]  = '{1'b1, 4'hF, 10'd999,  32'hCAFEF00D, 32'h0,        1'b0};
    vt[8]  = '{1'b1, 4'hF, 10'd1000, 32'h12345678, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 4'hF, 10'd1000, 32'h0,        32'h0,        1'b1};
    vt[10] = '{1'b0, 4'hF, 10'd999,  32'h0,        32'hCAFEF00D, 1'b0};
    vt[11] = '{1'b1, 4'hC, 10'd998,  32'h11223344, 32'h0,        1'b0};
    vt[12] = '{1'b0, 4'h8, 10'd998,  32'h0,        32'h11000000, 1'b0};

    aresetn = 1'b0; rsp_ready = 1'b1;
    req(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    repeat (2) cyc();
    chk("rst_ready", {31'b0, r0}, 32'd0);
    chk("rst_valid", {31'b0, v0}, 32'd0);
    chk("rst_rdata", d0, 32'h0);
    chk("rst_err",   {31'b0, e0}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    cyc();
    chk("post_rst_ready", {31'b0, r0}, 32'd1);

    // Table: one request, then check the cycle after (RD_LAT=1).
    for (int i = 0; i < 13; i++) begin
      req(1'b1, vt[i].wen, vt[i].be, vt[i].addr, vt[i].wdata);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'b0, r0}, 32'd1);
      chk($sformatf("v%0d_early_valid", i), {31'b0, v0}, 32'd0);
      cyc();
      req(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
      @(negedge clk);
      if (vt[i].wen) begin
        chk($sformatf("v%0d_no_wr_rsp", i), {31'b0, v0}, 32'd0);
      end else begin
        chk($sformatf("v%0d_valid", i), {31'b0, v0}, 32'd1);
        chk($sformatf("v%0d_rdata", i), d0, vt[i].exp_rdata);
        chk($sformatf("v%0d_err", i), {31'b0, e0}, {31'b0, vt[i].exp_err});
      end
      cyc();
    end

    // Preload addr 1..3 for the ordering tests.
    for (int a = 1; a <= 3; a++) begin
      req(1'b1, 1'b1, 4'hF, 10'(a), {4{8'(a * 8'h11)}});
      cyc();
    end
    idle(3);
    exp_q[0] = 32'h11111111; exp_q[1] = 32'h22222222; exp_q[2] = 32'h33333333;

    // Credit stall on u0: CAP=2, responses held, then drained in order.
    rsp_ready = 1'b0;
    req(1'b1, 1'b0, 4'hF, 10'd1, 32'h0);
    @(negedge clk); chk("t3_rdy_a", {31'b0, r0}, 32'd1);
    cyc();
    req(1'b1, 1'b0, 4'hF, 10'd2, 32'h0);
    @(negedge clk); chk("t3_rdy_b", {31'b0, r0}, 32'd1);
    chk("t3_head_b", d0, exp_q[0]);
    cyc();
    req(1'b1, 1'b0, 4'hF, 10'd3, 32'h0);
    @(negedge clk); chk("t3_rdy_c", {31'b0, r0}, 32'd0);
    chk("t3_valid_c", {31'b0, v0}, 32'd1);
    chk("t3_head_c", d0, exp_q[0]);
    cyc();
    rsp_ready = 1'b1;
    @(negedge clk); chk("t3_rdy_c2", {31'b0, r0}, 32'd0);
    chk("t3_hold", d0, exp_q[0]);
    cyc();
    @(negedge clk); chk("t3_rdy_d", {31'b0, r0}, 32'd1);
    chk("t3_rsp2", d0, exp_q[1]);
    cyc();
    req(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk); chk("t3_valid_e", {31'b0, v0}, 32'd1);
    chk("t3_rsp3", d0, exp_q[2]);
    cyc();
    @(negedge clk); chk("t3_empty", {31'b0, v0}, 32'd0);
    idle(5);

    // RD_LAT=2 on u1: write at N+1 must not affect read at N.
    req(1'b1, 1'b1, 4'hF, 10'd5, 32'hA5A5A5A5);
    cyc();
    idle(3);
    req(1'b1, 1'b0, 4'hF, 10'd5, 32'h0);
    @(negedge clk); chk("t5_rdy", {31'b0, r1}, 32'd1);
    cyc();
    req(1'b1, 1'b1, 4'hF, 10'd5, 32'h0);
    @(negedge clk); chk("t5_not_yet", {31'b0, v1}, 32'd0);
    cyc();
    req(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk); chk("t5_valid", {31'b0, v1}, 32'd1);
    chk("t5_prewrite", d1, 32'hA5A5A5A5);
    chk("t5_err", {31'b0, e1}, 32'd0);
    cyc();
    req(1'b1, 1'b0, 4'hF, 10'd5, 32'h0);
    cyc();
    req(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    cyc();
    @(negedge clk); chk("t5_postwrite", d1, 32'h0);
    chk("t5_valid2", {31'b0, v1}, 32'd1);
    idle(4);

    // u1 credit stall: CAP=3, then ordered drain from the FIFO.
    rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      req(1'b1, 1'b0, 4'hF, 10'(k + 1), 32'h0);
      @(negedge clk);
      if (r1) acc++;
      cyc();
    end
    idle(3);
    chk("t7_accepts", 32'(acc), 32'd3);
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t7_valid%0d", k), {31'b0, v1}, 32'd1);
      chk($sformatf("t7_order%0d", k), d1, exp_q[k]);
      cyc();
    end
    @(negedge clk); chk("t7_drained", {31'b0, v1}, 32'd0);
    idle(4);

    // Reset with two reads outstanding on u0 and responses stalled.
    rsp_ready = 1'b0;
    req(1'b1, 1'b0, 4'hF, 10'd1, 32'h0);
    cyc();
    req(1'b1, 1'b0, 4'hF, 10'd2, 32'h0);
    cyc();
    req(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk); chk("t6_pre_valid", {31'b0, v0}, 32'd1);
    chk("t6_pre_ready", {31'b0, r0}, 32'd0);
    @(posedge clk); #3;
    aresetn = 1'b0;
    #1;
    chk("t6_valid_async", {31'b0, v0}, 32'd0);
    chk("t6_ready_async", {31'b0, r0}, 32'd0);
    chk("t6_rdata_async", d0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t6_ready%0d", k), {31'b0, r0}, 32'd1);
      chk($sformatf("t6_stale%0d", k), {31'b0, v0}, 32'd0);
      cyc();
    end
    req(1'b1, 1'b0, 4'hF, 10'd999, 32'h0);
    cyc();
    req(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk); chk("t6_intact_valid", {31'b0, v0}, 32'd1);
    chk("t6_intact", d0, 32'hCAFEF00D);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
